slot_mask_decoder: RTL and testbench
====================================

Name: slot_mask_decoder

Overview:
- Inverse of the 32-way lowest-set-bit priority encoder used in the Memory subsystem.
- Takes 5-bit slot indices on two valid/ready channels, set (allocate) and clear (release), and decodes each to a one-hot mask.
- Maintains a registered 32-bit occupancy bitmap, an occupancy count, and sticky misuse flags.
- The priority encoder runs on free_mask to pick the next slot; this block owns the bitmap that the encoder reads.

Parameters:
- N_SLOTS, 32, number of tracked slots; must equal 2**IDX_W.
- IDX_W, 5, slot index width.
- CNT_W, 6, occupancy counter width; holds 0..N_SLOTS.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- set_valid  input  1  allocate request.
- set_idx  input  IDX_W  slot to mark busy.
- set_ready  output  1  allocate channel can accept.
- clr_valid  input  1  release request.
- clr_idx  input  IDX_W  slot to mark free.
- clr_ready  output  1  release channel can accept; tied high.
- flush  input  1  synchronous clear of the whole bitmap.
- err_clr  input  1  clears sticky error flags.
- busy_mask  output  N_SLOTS  registered occupancy bitmap.
- free_mask  output  N_SLOTS  bitwise inverse of busy_mask.
- onehot_out  output  N_SLOTS  registered one-hot of the last accepted set_idx.
- onehot_valid  output  1  one-cycle pulse qualifying onehot_out.
- count  output  CNT_W  number of busy slots.
- full  output  1  count == N_SLOTS.
- empty  output  1  count == 0.
- err_dset  output  1  sticky: set issued to a slot that was already busy.
- err_dfree  output  1  sticky: clear issued to a slot that was already free.

Behaviour:
- Reset state:
  - busy_mask=0, free_mask=all ones, count=0, empty=1, full=0.
  - onehot_out=0, onehot_valid=0, err_dset=0, err_dfree=0.
- Handshakes:
  - set_ready = !full, taken from registered count; no combinational path from the inputs.
  - clr_ready = 1 always.
  - A channel fires when valid && ready.
- Latency: a fire in cycle T updates busy_mask, count, full and empty, and pulses onehot_valid, all visible after edge T+1.
- Decode: mask = 1 << idx; the index width fully covers N_SLOTS, so no out-of-range case exists.
- Update order within one cycle:
  - Clear applies first: busy &= ~clr_mask.
  - Set applies second: busy |= set_mask.
- Same index set and cleared in one cycle:
  - Slot was busy: ends busy, count unchanged, no error.
  - Slot was free: ends busy, count +1, err_dfree is raised.
- Double set (slot already busy and not cleared in the same cycle): bitmap unchanged, count unchanged, err_dset <= 1. The onehot_valid pulse still occurs.
- Double free (slot already free): bitmap unchanged, count unchanged, err_dfree <= 1.
- Count update: next = count - (clear removed a busy bit) + (set added a new bit). Result is always in 0..N_SLOTS.
- When full, set_ready=0. A clr fired in the same cycle lowers count, so set_ready=1 from the next cycle.
- flush has priority over both channels:
  - busy_mask=0, count=0, onehot_valid=0.
  - Any set or clr fired in that cycle is consumed and discarded.
  - Error flags are not affected.
- err_clr: flags go to 0 unless a new error is detected in the same cycle; a new error wins.
- Reset mid-operation: all state returns to reset values immediately. In-flight requests are lost.

Decomposition:
- Shared package slot_pkg holds N_SLOTS, IDX_W, CNT_W and the slot index typedef. The priority encoder side uses the same package.
- One sub-module, slot_idx_dec: combinational IDX_W-to-N_SLOTS one-hot decoder, instantiated twice (set path and clear path).
- Bitmap, counter and flag registers live in the top module.

Test Plan:
- Reset, then set idx 0, 5, 31 on consecutive cycles -> busy_mask=0x80000021, count=3, onehot_out equals 0x1, 0x20, 0x80000000 on successive pulses.
- Set idx 5 twice -> second set leaves busy_mask unchanged, count stays 1, err_dset=1. Then err_clr -> err_dset=0.
- Set all 32 slots -> full=1, set_ready=0. Same cycle: set_valid with idx 3 plus clr idx 7 -> set not accepted, bit 7 cleared. Next cycle set_ready=1 and count=31.
- With slot 9 busy, set and clr idx 9 in the same cycle -> bit 9 stays 1, count unchanged, no error. Repeat with slot 9 free -> bit set, count +1, err_dfree=1.
- Clr idx 12 while free -> err_dfree=1, count stays 0. Flush with 10 slots busy plus a simultaneous set -> busy_mask=0, count=0, empty=1, no onehot_valid pulse.
- Assert rst_n low mid-stream with count=17 -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared slot-tracking constants and types.
// Used by the occupancy bitmap and the free-slot priority encoder.
package slot_pkg;

    localparam int N_SLOTS = 32;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 6;

    typedef logic [IDX_W-1:0] slot_idx_t;
    typedef logic [N_SLOTS-1:0] slot_mask_t;

endpackage

// File: rtl/slot_idx_dec.sv
// Combinational slot index to one-hot mask decoder.
// The index width covers every slot, so no range check is needed.
module slot_idx_dec
    import slot_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [N_SLOTS-1:0] mask
);

    localparam slot_mask_t ONE = slot_mask_t'(1);

    assign mask = ONE << idx;

endmodule

// File: rtl/slot_mask_decoder.sv
// Slot occupancy bitmap with allocate/release channels,
// occupancy count and sticky misuse flags.
module slot_mask_decoder
    import slot_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_valid,
    input  logic [IDX_W-1:0]   set_idx,
    output logic               set_ready,
    input  logic               clr_valid,
    input  logic [IDX_W-1:0]   clr_idx,
    output logic               clr_ready,
    input  logic               flush,
    input  logic               err_clr,
    output logic [N_SLOTS-1:0] busy_mask,
    output logic [N_SLOTS-1:0] free_mask,
    output logic [N_SLOTS-1:0] onehot_out,
    output logic               onehot_valid,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               err_dset,
    output logic               err_dfree
);

    slot_mask_t set_mask;
    slot_mask_t clr_mask;
    slot_mask_t after_clr;
    slot_mask_t busy_next;
    logic [CNT_W-1:0] count_next;
    logic set_fire;
    logic clr_fire;
    logic clr_hit;
    logic set_new;
    logic new_dset;
    logic new_dfree;

    slot_idx_dec u_set_dec (
        .idx  (set_idx),
        .mask (set_mask)
    );

    slot_idx_dec u_clr_dec (
        .idx  (clr_idx),
        .mask (clr_mask)
    );

    assign full      = (count == CNT_W'(N_SLOTS));
    assign empty     = (count == '0);
    assign set_ready = !full;
    assign clr_ready = 1'b1;
    assign free_mask = ~busy_mask;

    assign set_fire = set_valid && set_ready;
    assign clr_fire = clr_valid && clr_ready;

    // Clear applies before set; detect misuse against the right view.
    always_comb begin
        after_clr  = busy_mask;
        clr_hit    = 1'b0;
        new_dfree  = 1'b0;
        set_new    = 1'b0;
        new_dset   = 1'b0;
        if (clr_fire) begin
            clr_hit   = busy_mask[clr_idx];
            new_dfree = !busy_mask[clr_idx];
            after_clr = busy_mask & ~clr_mask;
        end
        busy_next = after_clr;
        if (set_fire) begin
            set_new   = !after_clr[set_idx];
            new_dset  = after_clr[set_idx];
            busy_next = after_clr | set_mask;
        end
        count_next = count - CNT_W'(clr_hit) + CNT_W'(set_new);
        if (flush) begin
            busy_next  = '0;
            count_next = '0;
            new_dset   = 1'b0;
            new_dfree  = 1'b0;
        end
    end

    // Bitmap, counter and one-hot pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_mask    <= '0;
            count        <= '0;
            onehot_out   <= '0;
            onehot_valid <= 1'b0;
        end else begin
            busy_mask    <= busy_next;
            count        <= count_next;
            onehot_valid <= set_fire && !flush;
            if (set_fire && !flush) begin
                onehot_out <= set_mask;
            end
        end
    end

    // Sticky misuse flags; a fresh error beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_dset  <= 1'b0;
            err_dfree <= 1'b0;
        end else begin
            err_dset  <= (err_dset && !err_clr) || new_dset;
            err_dfree <= (err_dfree && !err_clr) || new_dfree;
        end
    end

endmodule

// File: tb/tb_slot_mask_decoder.sv
// Directed self-checking bench for slot_mask_decoder.
// Expected values are hand-computed per scenario.
module tb_slot_mask_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        set_valid = 1'b0;
    logic [4:0]  set_idx = '0;
    logic        set_ready;
    logic        clr_valid = 1'b0;
    logic [4:0]  clr_idx = '0;
    logic        clr_ready;
    logic        flush = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] busy_mask;
    logic [31:0] free_mask;
    logic [31:0] onehot_out;
    logic        onehot_valid;
    logic [5:0]  count;
    logic        full;
    logic        empty;
    logic        err_dset;
    logic        err_dfree;

    int n_tests = 0;
    int n_fail  = 0;

    slot_mask_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_valid    (set_valid),
        .set_idx      (set_idx),
        .set_ready    (set_ready),
        .clr_valid    (clr_valid),
        .clr_idx      (clr_idx),
        .clr_ready    (clr_ready),
        .flush        (flush),
        .err_clr      (err_clr),
        .busy_mask    (busy_mask),
        .free_mask    (free_mask),
        .onehot_out   (onehot_out),
        .onehot_valid (onehot_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .err_dset     (err_dset),
        .err_dfree    (err_dfree)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_valid = 1'b0;
        clr_valid = 1'b0;
        flush     = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic do_set(input logic [4:0] i);
        idle();
        set_valid = 1'b1;
        set_idx   = i;
        tick();
        set_valid = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_busy", busy_mask, 32'h0);
        check("rst_free", free_mask, 32'hffff_ffff);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_oh", onehot_out, 32'h0);
        check("rst_ohv", 32'(onehot_valid), 32'd0);
        check("rst_errs", 32'({err_dset, err_dfree}), 32'd0);
        check("rst_rdy", 32'({set_ready, clr_ready}), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // set 0, 5, 31 back to back
        set_valid = 1'b1;
        set_idx = 5'd0;
        tick();
        check("oh0", onehot_out, 32'h1);
        check("ohv0", 32'(onehot_valid), 32'd1);
        set_idx = 5'd5;
        tick();
        check("oh5", onehot_out, 32'h20);
        set_idx = 5'd31;
        tick();
        check("oh31", onehot_out, 32'h8000_0000);
        idle();
        tick();
        check("ohv_off", 32'(onehot_valid), 32'd0);
        check("busy3", busy_mask, 32'h8000_0021);
        check("free3", free_mask, 32'h7fff_ffde);
        check("cnt3", 32'(count), 32'd3);
        check("empty3", 32'(empty), 32'd0);

        // double set
        do_flush();
        check("fl_empty", 32'(empty), 32'd1);
        do_set(5'd5);
        do_set(5'd5);
        check("dset_ohv", 32'(onehot_valid), 32'd1);
        check("dset_busy", busy_mask, 32'h20);
        check("dset_cnt", 32'(count), 32'd1);
        check("dset_err", 32'(err_dset), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("dset_clr", 32'(err_dset), 32'd0);

        // fill all slots, then set+clr while full
        do_flush();
        for (int i = 0; i < 32; i++) do_set(5'(i));
        check("full_cnt", 32'(count), 32'd32);
        check("full", 32'(full), 32'd1);
        check("full_rdy", 32'(set_ready), 32'd0);
        check("full_free", free_mask, 32'h0);
        set_valid = 1'b1;
        set_idx = 5'd3;
        clr_valid = 1'b1;
        clr_idx = 5'd7;
        tick();
        idle();
        check("fc_busy", busy_mask, 32'hffff_ff7f);
        check("fc_cnt", 32'(count), 32'd31);
        check("fc_rdy", 32'(set_ready), 32'd1);
        check("fc_ohv", 32'(onehot_valid), 32'd0);
        check("fc_err", 32'({err_dset, err_dfree}), 32'd0);

        // same index set and clear
        do_flush();
        do_set(5'd9);
        set_valid = 1'b1;
        set_idx = 5'd9;
        clr_valid = 1'b1;
        clr_idx = 5'd9;
        tick();
        idle();
        check("sc_busy", busy_mask, 32'h200);
        check("sc_cnt", 32'(count), 32'd1);
        check("sc_err", 32'({err_dset, err_dfree}), 32'd0);
        clr_valid = 1'b1;
        clr_idx = 5'd9;
        tick();
        idle();
        check("clr9", busy_mask, 32'h0);
        set_valid = 1'b1;
        set_idx = 5'd9;
        clr_valid = 1'b1;
        clr_idx = 5'd9;
        tick();
        idle();
        check("scf_busy", busy_mask, 32'h200);
        check("scf_cnt", 32'(count), 32'd1);
        check("scf_dfree", 32'(err_dfree), 32'd1);
        check("scf_dset", 32'(err_dset), 32'd0);

        // double free, err_clr vs new error
        do_flush();
        err_clr = 1'b1;
        tick();
        idle();
        check("ec_dfree", 32'(err_dfree), 32'd0);
        clr_valid = 1'b1;
        clr_idx = 5'd12;
        tick();
        idle();
        check("df_err", 32'(err_dfree), 32'd1);
        check("df_cnt", 32'(count), 32'd0);
        err_clr = 1'b1;
        clr_valid = 1'b1;
        clr_idx = 5'd12;
        tick();
        idle();
        check("ec_win", 32'(err_dfree), 32'd1);

        // flush beats a simultaneous set
        for (int i = 0; i < 10; i++) do_set(5'(i));
        check("ten_cnt", 32'(count), 32'd10);
        flush = 1'b1;
        set_valid = 1'b1;
        set_idx = 5'd20;
        tick();
        idle();
        check("fl_busy", busy_mask, 32'h0);
        check("fl_cnt", 32'(count), 32'd0);
        check("fl_empty2", 32'(empty), 32'd1);
        check("fl_ohv", 32'(onehot_valid), 32'd0);
        check("fl_keep", 32'(err_dfree), 32'd1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 17; i++) do_set(5'(i));
        check("pre_cnt", 32'(count), 32'd17);
        set_valid = 1'b1;
        set_idx = 5'd20;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", busy_mask, 32'h0);
        check("ar_cnt", 32'(count), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_oh", onehot_out, 32'h0);
        check("ar_ohv", 32'(onehot_valid), 32'd0);
        check("ar_err", 32'({err_dset, err_dfree}), 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
